// File: rtl/timer_regs_pkg.sv
// ---------------------------------------------------------------------------
// timer_regs_pkg
//  Shared constants for the timer bus register front end: register byte
//  addresses, CTRL bit positions and a byte-extract helper used by the
//  read-data muxes.
// ---------------------------------------------------------------------------
package timer_regs_pkg;

   // Register byte addresses (5-bit bus address space)
   localparam logic [4:0] ADDR_CTRL     = 5'h00;
   localparam logic [4:0] ADDR_STATUS   = 5'h01;
   localparam logic [4:0] ADDR_IRQ_EN   = 5'h02;
   localparam logic [4:0] ADDR_CMP_BASE = 5'h08;
   localparam logic [4:0] ADDR_CNT_BASE = 5'h10;

   // CTRL bit positions
   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_CLR_BIT = 1;
   localparam int CTRL_PER_BIT = 2;

   // Byte index whose write commits the compare shadow
   localparam logic [2:0] CMP_COMMIT_BYTE = 3'd7;

   // Byte idx of a 64-bit word; callers zero-extend narrower words so
   // unimplemented bytes read back as 0.
   function automatic logic [7:0] byte_of(input logic [63:0] v, input logic [2:0] idx);
      return v[idx*8 +: 8];
   endfunction

endpackage

// File: rtl/timer_regs_bytelane.sv
// ---------------------------------------------------------------------------
// timer_regs_bytelane
//  W-bit register writable one byte at a time or loaded as a whole word.
//  Used both as the compare shadow (byte writes) and the count snapshot
//  (whole-word load).
// Ports
//  clock, reset    rising-edge clock, async active-high reset
//  byte_we_i       write byte_wdata_i into byte byte_sel_i
//  byte_sel_i      byte index; indices >= W/8 are ignored
//  byte_wdata_i    byte write data
//  load_i          load load_data_i into the whole word (wins over byte write)
//  load_data_i     whole-word load data
//  word_q_o        registered word
// ---------------------------------------------------------------------------
module timer_regs_bytelane #(
   parameter int W = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         byte_we_i,
   input  logic [2:0]   byte_sel_i,
   input  logic [7:0]   byte_wdata_i,
   input  logic         load_i,
   input  logic [W-1:0] load_data_i,
   output logic [W-1:0] word_q_o
);

   localparam int NB = W / 8;

   logic [W-1:0] word_q, word_d;

   always_comb begin
      word_d = word_q;
      if (load_i) begin
         word_d = load_data_i;
      end else if (byte_we_i) begin
         for (int b = 0; b < NB; b++) begin
            if (byte_sel_i == 3'(b)) word_d[b*8 +: 8] = byte_wdata_i;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) word_q <= '0;
      else       word_q <= word_d;
   end

   assign word_q_o = word_q;

endmodule

// File: rtl/timer_bus_regs.sv
// ---------------------------------------------------------------------------
// timer_bus_regs
//  Bus-side register front end for the SoC timer. CPU writes drive the
//  timer control byte and a double-buffered compare value; reads of the
//  count return an atomic snapshot latched on the byte-0 read. Rising
//  edges of the timer's match level set a sticky, maskable interrupt.
//
//  Optional feature macro: TIMER_REGS_PERIODIC_EN
//   defined   : CTRL<2> (periodic) is rw; each captured match edge also
//               pulses control_reg[1] so the timer restarts from 0.
//   undefined : CTRL<2> reads 0, writes ignored, no hardware clears.
//
// Ports
//  clock, reset          rising-edge clock, async active-high reset
//  bus_req/we/addr/wdata one-cycle access strobe, direction, address, data
//  bus_rdata, bus_ack    read data + ack, exactly one cycle after bus_req
//  control_reg           <0> enable, <1> one-cycle clear pulse
//  timer_compare_value   committed compare value
//  timer_value           live count from the timer
//  timer_compare_match   registered equality level from the timer
//  irq                   registered pending & irq_en
// ---------------------------------------------------------------------------
module timer_bus_regs
   import timer_regs_pkg::*;
#(
   parameter int COUNT_WIDTH = 64,
   parameter int ADDR_WIDTH  = 5
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   bus_req,
   input  logic                   bus_we,
   input  logic [ADDR_WIDTH-1:0]  bus_addr,
   input  logic [7:0]             bus_wdata,
   output logic [7:0]             bus_rdata,
   output logic                   bus_ack,
   output logic [7:0]             control_reg,
   output logic [COUNT_WIDTH-1:0] timer_compare_value,
   input  logic [COUNT_WIDTH-1:0] timer_value,
   input  logic                   timer_compare_match,
   output logic                   irq
);

   localparam int NUM_BYTES = COUNT_WIDTH / 8;

   localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(ADDR_CTRL);
   localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(ADDR_STATUS);
   localparam logic [ADDR_WIDTH-1:0] A_IRQ_EN = ADDR_WIDTH'(ADDR_IRQ_EN);
   localparam logic [ADDR_WIDTH-1:0] A_CMP    = ADDR_WIDTH'(ADDR_CMP_BASE);
   localparam logic [ADDR_WIDTH-1:0] A_CNT    = ADDR_WIDTH'(ADDR_CNT_BASE);

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic       wr, rd, cmp_hit, cnt_hit;
   logic       ctrl_wr, status_w1c, irq_en_wr, commit;
   logic [2:0] byte_sel;

   assign wr       = bus_req &  bus_we;
   assign rd       = bus_req & ~bus_we;
   assign byte_sel = bus_addr[2:0];
   assign cmp_hit  = (bus_addr[ADDR_WIDTH-1:3] == A_CMP[ADDR_WIDTH-1:3]);
   assign cnt_hit  = (bus_addr[ADDR_WIDTH-1:3] == A_CNT[ADDR_WIDTH-1:3]);

   assign ctrl_wr    = wr & (bus_addr == A_CTRL);
   assign status_w1c = wr & (bus_addr == A_STATUS) & bus_wdata[0];
   assign irq_en_wr  = wr & (bus_addr == A_IRQ_EN);
   assign commit     = wr & cmp_hit & (byte_sel == CMP_COMMIT_BYTE);

   // ------------------------------------------------------------------
   // Compare shadow and count snapshot
   // ------------------------------------------------------------------
   logic [COUNT_WIDTH-1:0] shadow_q, snap_q, cmp_commit, cmp_q;

   timer_regs_bytelane #(.W(COUNT_WIDTH)) u_cmp_shadow (
      .clock        (clock),
      .reset        (reset),
      .byte_we_i    (wr & cmp_hit),
      .byte_sel_i   (byte_sel),
      .byte_wdata_i (bus_wdata),
      .load_i       (1'b0),
      .load_data_i  ('0),
      .word_q_o     (shadow_q)
   );

   // Snapshot is taken on the byte-0 read so bytes 1..7 never tear.
   timer_regs_bytelane #(.W(COUNT_WIDTH)) u_cnt_snap (
      .clock        (clock),
      .reset        (reset),
      .byte_we_i    (1'b0),
      .byte_sel_i   (byte_sel),
      .byte_wdata_i (bus_wdata),
      .load_i       (rd & cnt_hit & (byte_sel == 3'd0)),
      .load_data_i  (timer_value),
      .word_q_o     (snap_q)
   );

   // The top byte arrives with the committing write itself, so it is
   // merged from bus_wdata rather than from the (not yet updated) shadow.
   always_comb begin
      cmp_commit = shadow_q;
      if (NUM_BYTES == 8) cmp_commit[COUNT_WIDTH-1 -: 8] = bus_wdata;
   end

   // ------------------------------------------------------------------
   // Control, status, interrupt
   // ------------------------------------------------------------------
   logic enable_q, enable_d;
   logic clear_q, clear_d;
   logic pending_q, pending_d;
   logic irq_en_q, irq_en_d;
   logic match_prev_q, match_rise;
   logic irq_q;
   logic ack_q;
   logic [7:0] rdata_q, rdata_d;
   logic periodic, hw_clear;

   assign match_rise = timer_compare_match & ~match_prev_q;

`ifdef TIMER_REGS_PERIODIC_EN
   logic periodic_q, periodic_d;

   assign periodic_d = ctrl_wr ? bus_wdata[CTRL_PER_BIT] : periodic_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) periodic_q <= 1'b0;
      else       periodic_q <= periodic_d;
   end

   assign periodic = periodic_q;
   assign hw_clear = match_rise & periodic_q;
`else
   assign periodic = 1'b0;
   assign hw_clear = 1'b0;
`endif

   assign enable_d = ctrl_wr ? bus_wdata[CTRL_EN_BIT] : enable_q;
   assign clear_d  = (ctrl_wr & bus_wdata[CTRL_CLR_BIT]) | hw_clear;
   assign irq_en_d = irq_en_wr ? bus_wdata[0] : irq_en_q;
   // A new match edge in the same cycle as a W1C keeps pending set.
   assign pending_d = match_rise | (pending_q & ~status_w1c);

   // ------------------------------------------------------------------
   // Read mux (registered into rdata_q alongside the ack)
   // ------------------------------------------------------------------
   always_comb begin
      rdata_d = '0;
      if (rd) begin
         if (bus_addr == A_CTRL) begin
            rdata_d[CTRL_EN_BIT]  = enable_q;
            rdata_d[CTRL_PER_BIT] = periodic;
         end else if (bus_addr == A_STATUS) begin
            rdata_d[0] = pending_q;
         end else if (bus_addr == A_IRQ_EN) begin
            rdata_d[0] = irq_en_q;
         end else if (cmp_hit) begin
            rdata_d = byte_of(64'(cmp_q), byte_sel);
         end else if (cnt_hit) begin
            rdata_d = (byte_sel == 3'd0) ? byte_of(64'(timer_value), 3'd0)
                                         : byte_of(64'(snap_q), byte_sel);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ack_q        <= 1'b0;
         rdata_q      <= '0;
         enable_q     <= 1'b0;
         clear_q      <= 1'b0;
         pending_q    <= 1'b0;
         irq_en_q     <= 1'b0;
         match_prev_q <= 1'b0;
         irq_q        <= 1'b0;
         cmp_q        <= '0;
      end else begin
         ack_q        <= bus_req;
         rdata_q      <= rdata_d;
         enable_q     <= enable_d;
         clear_q      <= clear_d;
         pending_q    <= pending_d;
         irq_en_q     <= irq_en_d;
         match_prev_q <= timer_compare_match;
         irq_q        <= pending_q & irq_en_q;
         if (commit) cmp_q <= cmp_commit;
      end
   end

   assign bus_ack             = ack_q;
   assign bus_rdata           = rdata_q;
   assign control_reg         = {6'b0, clear_q, enable_q};
   assign timer_compare_value = cmp_q;
   assign irq                 = irq_q;

endmodule
